// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch unit with AXI4 burst prefetch into an instruction queue
//
// Fetches instructions with AXI4 INCR read bursts and queues them for the IDU.
// Each burst stops at a BURST_LEN*4-byte block boundary. Queue space for a
// whole burst is reserved before AR is issued. A redirect flushes the queue and
// drains any outstanding burst.
//
// Ports:
//   clock, reset                  clock and asynchronous active-low reset
//   redirect_valid, redirect_pc   one-cycle restart request and its target PC
//   idu_valid/idu_ready           head-of-queue handshake toward the decoder
//   idu_pc, idu_inst, idu_err     head entry: PC, instruction, error-response flag
//   io_master_ar*                 AXI4 read address channel (master side)
//   io_master_r*                  AXI4 read data channel (master side)
//   state_out                     FSM state for debug (IDLE=0 ADDR=1 DATA=2 DRAIN=3)
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h3000_0000,
  parameter int          BURST_LEN  = 4,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        idu_ready,
  output logic        idu_valid,
  output logic [31:0] idu_pc,
  output logic [31:0] idu_inst,
  output logic        idu_err,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  input  logic        io_master_rvalid,
  input  logic [31:0] io_master_rdata,
  input  logic [3:0]  io_master_rid,
  input  logic        io_master_rlast,
  input  logic [1:0]  io_master_rresp,
  output logic        io_master_rready,
  output logic [1:0]  state_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ADDR  = 2'b01,
    DATA  = 2'b10,
    DRAIN = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [31:0]   beat_pc_q, beat_pc_d;
  logic [7:0]    arlen_q, arlen_d;
  logic [3:0]    curr_id_q, curr_id_d;
  logic          redir_pend_q, redir_pend_d;

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   q_pc   [FIFO_DEPTH];
  logic [31:0]   q_inst [FIFO_DEPTH];
  logic          q_err  [FIFO_DEPTH];

  logic [31:0]   blk_off;
  logic [4:0]    len;
  logic [CW-1:0] free;
  logic          match;
  logic          push;
  logic          pop;
  logic          has_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Beats left to the end of the current aligned block.
  assign blk_off = (fetch_pc_q >> 2) & 32'(BURST_LEN - 1);
  assign len     = 5'(32'(BURST_LEN) - blk_off);
  assign free    = CW'(FIFO_DEPTH) - count_q;
  assign match   = io_master_rvalid && (io_master_rid == curr_id_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      araddr_q     <= '0;
      beat_pc_q    <= '0;
      arlen_q      <= '0;
      curr_id_q    <= '0;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      araddr_q     <= araddr_d;
      beat_pc_q    <= beat_pc_d;
      arlen_q      <= arlen_d;
      curr_id_q    <= curr_id_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    fetch_pc_d        = fetch_pc_q;
    araddr_d          = araddr_q;
    beat_pc_d         = beat_pc_q;
    arlen_d           = arlen_q;
    curr_id_d         = curr_id_q;
    redir_pend_d      = redir_pend_q;
    push              = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && (32'(free) >= 32'(len))) begin
          state_d      = ADDR;
          araddr_d     = fetch_pc_q;
          arlen_d      = 8'(len) - 8'd1;
          curr_id_d    = curr_id_q + 4'd1;
          redir_pend_d = 1'b0;
        end
      end
      ADDR: begin
        io_master_arvalid = 1'b1;
        // A redirect while AR waits is remembered so the burst gets drained.
        if (redirect_valid) redir_pend_d = 1'b1;
        if (io_master_arready) begin
          state_d      = (redir_pend_q || redirect_valid) ? DRAIN : DATA;
          beat_pc_d    = araddr_q;
          redir_pend_d = 1'b0;
        end
      end
      DATA: begin
        io_master_rready = 1'b1;
        if (redirect_valid) begin
          // Redirect on the final beat: nothing left to drain.
          state_d = (match && io_master_rlast) ? IDLE : DRAIN;
        end else if (match) begin
          push      = 1'b1;
          beat_pc_d = beat_pc_q + 32'd4;
          if (io_master_rlast) begin
            state_d    = IDLE;
            fetch_pc_d = beat_pc_q + 32'd4;
          end
        end
      end
      DRAIN: begin
        io_master_rready = 1'b1;
        if (match && io_master_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
  end

  assign has_head  = (count_q != '0);
  assign idu_valid = has_head && !redirect_valid;
  assign pop       = idu_valid && idu_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr_q]   <= beat_pc_q;
      q_inst[wr_ptr_q] <= io_master_rdata;
      q_err[wr_ptr_q]  <= (io_master_rresp != 2'b00);
    end
  end

  assert property (@(posedge clock) disable iff (!reset) !(push && (count_q == CW'(FIFO_DEPTH))));

  // Head fields read as zero when the queue is empty (storage is not reset).
  assign idu_pc   = has_head ? q_pc[rd_ptr_q]   : '0;
  assign idu_inst = has_head ? q_inst[rd_ptr_q] : '0;
  assign idu_err  = has_head ? q_err[rd_ptr_q]  : 1'b0;

  assign io_master_araddr  = araddr_q;
  assign io_master_arid    = curr_id_q;
  assign io_master_arlen   = arlen_q;
  assign io_master_arsize  = 3'b010;
  assign io_master_arburst = 2'b01;
  assign state_out         = state_q;

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - scoreboard testbench for ifu_prefetch with a behavioural AXI read slave
module tb_ifu_prefetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        idu_ready = 1'b0;
  logic        idu_valid;
  logic [31:0] idu_pc;
  logic [31:0] idu_inst;
  logic        idu_err;
  logic        io_master_arready = 1'b0;
  logic        io_master_arvalid;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_rvalid = 1'b0;
  logic [31:0] io_master_rdata = '0;
  logic [3:0]  io_master_rid = '0;
  logic        io_master_rlast = 1'b0;
  logic [1:0]  io_master_rresp = '0;
  logic        io_master_rready;
  logic [1:0]  state_out;

  ifu_prefetch dut (
    .clock             (clock),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .idu_ready         (idu_ready),
    .idu_valid         (idu_valid),
    .idu_pc            (idu_pc),
    .idu_inst          (idu_inst),
    .idu_err           (idu_err),
    .io_master_arready (io_master_arready),
    .io_master_arvalid (io_master_arvalid),
    .io_master_araddr  (io_master_araddr),
    .io_master_arid    (io_master_arid),
    .io_master_arlen   (io_master_arlen),
    .io_master_arsize  (io_master_arsize),
    .io_master_arburst (io_master_arburst),
    .io_master_rvalid  (io_master_rvalid),
    .io_master_rdata   (io_master_rdata),
    .io_master_rid     (io_master_rid),
    .io_master_rlast   (io_master_rlast),
    .io_master_rresp   (io_master_rresp),
    .io_master_rready  (io_master_rready),
    .state_out         (state_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } ar_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } idu_t;

  ar_t  exp_ar[$];
  idu_t exp_idu[$];
  ar_t  ea;
  idu_t ei;
  int   vectors = 0;
  int   miscompares = 0;

  // Memory slave knobs.
  int          ar_budget = 0;
  int          mem_gap = 0;
  logic        mem_stray = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_idu(input logic [31:0] pc, input logic err);
    ei = '{pc: pc, inst: inst_of(pc), err: err};
    exp_idu.push_back(ei);
  endtask

  // err_beat: index of the beat expected to carry an error response, -1 for none.
  task automatic expect_burst(input logic [31:0] addr, input int beats, input logic [3:0] id,
                              input int err_beat);
    ea = '{addr: addr, len: 8'(beats - 1), id: id};
    exp_ar.push_back(ea);
    for (int i = 0; i < beats; i++) push_idu(addr + 32'(4 * i), i == err_beat);
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while ((exp_ar.size() != 0 || exp_idu.size() != 0) && n < max_cycles) begin
      @(posedge clock); #1;
      n++;
    end
    vectors++;
    if (exp_ar.size() != 0 || exp_idu.size() != 0) begin
      miscompares++;
      $display("FAIL %s: timeout with %0d AR and %0d IDU responses outstanding, want 0",
               name, exp_ar.size(), exp_idu.size());
      exp_ar.delete();
      exp_idu.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, 64'(io_master_arvalid), 64'd0);
    check({tag, "_rready"},  64'(io_master_rready),  64'd0);
    check({tag, "_idu_valid"}, 64'(idu_valid), 64'd0);
    check({tag, "_idu_err"}, 64'(idu_err),  64'd0);
    check({tag, "_idu_pc"},  64'(idu_pc),   64'd0);
    check({tag, "_idu_inst"}, 64'(idu_inst), 64'd0);
    check({tag, "_state"},   64'(state_out), 64'd0);
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    idu_ready      = 1'b0;
    ar_budget      = 0;
    mem_gap        = 0;
    mem_stray      = 1'b0;
    err_addr       = 32'hFFFF_FFFF;
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: inputs change only at posedge+1, so negedge values are what the DUT samples.
  always @(negedge clock) begin
    if (reset && io_master_arvalid && io_master_arready) begin
      if (exp_ar.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL ar_unexpected: got addr %h len %0d id %0d, want no AR",
                 io_master_araddr, io_master_arlen, io_master_arid);
      end else begin
        ea = exp_ar.pop_front();
        check("ar_addr", 64'(io_master_araddr), 64'(ea.addr));
        check("ar_len", 64'(io_master_arlen), 64'(ea.len));
        check("ar_id", 64'(io_master_arid), 64'(ea.id));
        check("ar_size", 64'(io_master_arsize), 64'd2);
        check("ar_burst", 64'(io_master_arburst), 64'd1);
      end
    end
    if (reset && idu_valid && idu_ready) begin
      if (exp_idu.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL idu_unexpected: got pc %h, want no instruction", idu_pc);
      end else begin
        ei = exp_idu.pop_front();
        check("idu_pc", 64'(idu_pc), 64'(ei.pc));
        check("idu_inst", 64'(idu_inst), 64'(ei.inst));
        check("idu_err", 64'(idu_err), 64'(ei.err));
      end
    end
  end

  // Behavioural AXI read slave: one burst at a time, mem_gap idle cycles before each beat,
  // optional stray beat with a foreign rid ahead of the real data.
  int          b_left = 0;
  int          gap = 0;
  logic [31:0] b_addr = '0;
  logic [3:0]  b_id = '0;
  logic        stray_pend = 1'b0;
  logic        stray_drv = 1'b0;
  logic        ar_fire_s;
  logic        r_fire_s;

  always @(negedge clock) begin
    if (io_master_arvalid) check("ar_during_burst", 64'(b_left), 64'd0);
  end

  initial begin
    forever begin
      @(negedge clock);
      ar_fire_s = io_master_arvalid && io_master_arready;
      r_fire_s  = io_master_rvalid && io_master_rready;
      @(posedge clock);
      #1;
      if (!reset) begin
        b_left = 0;
        gap = 0;
        stray_pend = 1'b0;
        stray_drv = 1'b0;
        io_master_arready = 1'b0;
        io_master_rvalid = 1'b0;
        io_master_rlast = 1'b0;
      end else begin
        if (ar_fire_s) begin
          b_addr     = io_master_araddr;
          b_left     = int'(io_master_arlen) + 1;
          b_id       = io_master_arid;
          ar_budget  = ar_budget - 1;
          gap        = mem_gap;
          stray_pend = mem_stray;
        end else if (r_fire_s) begin
          if (stray_drv) begin
            stray_pend = 1'b0;
          end else begin
            b_left = b_left - 1;
            b_addr = b_addr + 32'd4;
          end
          gap = mem_gap;
        end
        io_master_arready = (ar_budget > 0) && (b_left == 0);
        stray_drv = 1'b0;
        io_master_rvalid = 1'b0;
        io_master_rlast = 1'b0;
        if (b_left > 0) begin
          if (gap > 0) begin
            gap = gap - 1;
          end else if (stray_pend) begin
            io_master_rvalid = 1'b1;
            stray_drv        = 1'b1;
            io_master_rid    = b_id + 4'd1;
            io_master_rdata  = '0;
            io_master_rresp  = 2'b00;
            io_master_rlast  = 1'b1;
          end else begin
            io_master_rvalid = 1'b1;
            io_master_rid    = b_id;
            io_master_rdata  = inst_of(b_addr);
            io_master_rresp  = (b_addr == err_addr) ? 2'b10 : 2'b00;
            io_master_rlast  = (b_left == 1);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    // Reset values, then two back-to-back zero-wait bursts.
    do_reset();
    check_reset_outputs("rst");
    idu_ready = 1'b1;
    expect_burst(32'h3000_0000, 4, 4'd1, -1);
    expect_burst(32'h3000_0010, 4, 4'd2, -1);
    ar_budget = 2;
    reset = 1'b1;
    wait_drain("t1_stream", 100);

    // Redirect in IDLE to a non-aligned PC: short burst to the block edge, then a full one.
    do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000_010A;
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    check("t2_idle_on_redirect", 64'(state_out), 64'd0);
    idu_ready = 1'b1;
    expect_burst(32'h3000_0108, 2, 4'd1, -1);
    expect_burst(32'h3000_0110, 4, 4'd2, -1);
    ar_budget = 2;
    wait_drain("t2_redirect", 100);

    // Back-pressure: queue fills, AR waits until a whole burst fits.
    do_reset();
    reset = 1'b1;
    expect_burst(32'h3000_0000, 4, 4'd1, -1);
    expect_burst(32'h3000_0010, 4, 4'd2, -1);
    ar_budget = 3;
    repeat (30) @(posedge clock);
    #1;
    check("t3_two_ars_done", 64'(exp_ar.size()), 64'd0);
    check("t3_full_state", 64'(state_out), 64'd0);
    check("t3_full_arvalid", 64'(io_master_arvalid), 64'd0);
    check("t3_full_idu_valid", 64'(idu_valid), 64'd1);
    idu_ready = 1'b1;
    @(posedge clock); #1;
    idu_ready = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("t3_one_pop_state", 64'(state_out), 64'd0);
    idu_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    idu_ready = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("t3_count5_state", 64'(state_out), 64'd0);
    check("t3_count5_arvalid", 64'(io_master_arvalid), 64'd0);
    expect_burst(32'h3000_0020, 4, 4'd3, -1);
    idu_ready = 1'b1;
    wait_drain("t3_backpressure", 100);

    // Redirect after the first beat of a slow burst: stale beats drained, never delivered.
    do_reset();
    reset     = 1'b1;
    idu_ready = 1'b1;
    mem_gap   = 3;
    ar_budget = 2;
    ea = '{addr: 32'h3000_0000, len: 8'd3, id: 4'd1};
    exp_ar.push_back(ea);
    push_idu(32'h3000_0000, 1'b0);
    wait_drain("t4_first_beat", 40);
    expect_burst(32'h3000_0200, 4, 4'd2, -1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000_0200;
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    check("t4_drain_state", 64'(state_out), 64'd3);
    check("t4_queue_flushed", 64'(idu_valid), 64'd0);
    wait_drain("t4_redirect", 200);

    // Error response on beat 2, with a foreign-rid beat ahead of the burst.
    do_reset();
    err_addr  = 32'h3000_0004;
    mem_stray = 1'b1;
    reset     = 1'b1;
    idu_ready = 1'b1;
    expect_burst(32'h3000_0000, 4, 4'd1, 1);
    ar_budget = 1;
    wait_drain("t5_error_beat", 100);

    // Asynchronous reset in DATA with two beats still pending.
    do_reset();
    reset     = 1'b1;
    idu_ready = 1'b1;
    mem_gap   = 3;
    ar_budget = 1;
    ea = '{addr: 32'h3000_0000, len: 8'd3, id: 4'd1};
    exp_ar.push_back(ea);
    push_idu(32'h3000_0000, 1'b0);
    push_idu(32'h3000_0004, 1'b0);
    wait_drain("t6_two_beats", 60);
    check("t6_in_data", 64'(state_out), 64'd2);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    mem_gap = 0;
    repeat (2) @(posedge clock);
    #1;
    expect_burst(32'h3000_0000, 4, 4'd1, -1);
    ar_budget = 1;
    reset = 1'b1;
    wait_drain("t6_restart", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
